// File: rtl/rrs_add_pkg.sv
// Shared types and digit-arithmetic helpers for the radix-r MSDF online adder.
// The selection functions are common to the serial and the parallel online adders.
package rrs_add_pkg;

    localparam int SW = 8;

    typedef logic signed [SW-1:0] sdig_t;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    // Transfer digit t and interim digit w for one position.
    typedef struct packed {
        sdig_t t;
        sdig_t w;
    } sel_t;

    function automatic int digit_width(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int online_delay(input int radix);
        return (radix == 2) ? 2 : 1;
    endfunction

    // Radix > 2: p in [-2A, 2A] maps to t in {-1,0,1} with w = p - t*r.
    function automatic sel_t select_digit(input int radix, input sdig_t p);
        sel_t  s;
        sdig_t r;
        sdig_t a;
        r = sdig_t'(radix);
        a = r - 8'sd1;
        if (p >= a) begin
            s.t = 8'sd1;
            s.w = p - r;
        end else if (p <= -a) begin
            s.t = -8'sd1;
            s.w = p + r;
        end else begin
            s.t = 8'sd0;
            s.w = p;
        end
        return s;
    endfunction

    // Radix 2 first stage: t carries h, w carries z.
    function automatic sel_t split_pair_r2(input sdig_t p);
        sel_t s;
        if (p > 8'sd0) begin
            s.t = 8'sd1;
            s.w = p - 8'sd2;
        end else begin
            s.t = 8'sd0;
            s.w = p;
        end
        return s;
    endfunction

    function automatic sel_t resolve_r2(input sdig_t v);
        sel_t s;
        if (v < 8'sd0) begin
            s.t = -8'sd1;
            s.w = v + 8'sd2;
        end else begin
            s.t = 8'sd0;
            s.w = v;
        end
        return s;
    endfunction

endpackage

// File: rtl/rrs_add_digit_sel.sv
// Combinational transfer/interim selection for one digit position of the online adder.
// Radix 2 needs a two-stage (h/z then t/w) selection, hence the extra z history input.
module rrs_add_digit_sel
    import rrs_add_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int D     = 3
) (
    input  logic         first_i,
    input  logic [D-1:0] x_i,
    input  logic [D-1:0] y_i,
    input  sdig_t        w_i,
    input  sdig_t        z_i,
    output logic [D-1:0] sum_o,
    output sdig_t        w_o,
    output sdig_t        z_o
);

    sdig_t p_s;

    assign p_s = sdig_t'($signed(x_i)) + sdig_t'($signed(y_i));

    generate
        if (RADIX == 2) begin : g_r2
            sel_t hz_s;
            sel_t tw_s;

            // Resolve position j-1 once its incoming h_j is known; step 0 seeds w with h_0.
            always_comb begin
                hz_s = split_pair_r2(p_s);
                tw_s = resolve_r2(z_i + hz_s.t);
                if (first_i) begin
                    w_o = hz_s.t;
                end else begin
                    w_o = tw_s.w;
                end
            end

            assign sum_o = D'(w_i + tw_s.t);
            assign z_o   = hz_s.w;
        end else begin : g_rn
            sel_t tw_s;
            logic unused_s;

            assign tw_s     = select_digit(RADIX, p_s);
            assign sum_o    = D'(w_i + tw_s.t);
            assign w_o      = tw_s.w;
            assign z_o      = {SW{1'b0}};
            assign unused_s = ^{first_i, z_i};
        end
    endgenerate

endmodule

// File: rtl/rrs_add.sv
// Digit-serial MSDF online adder for radix-r maximally redundant signed digits.
// WIDTH digit pairs in, WIDTH+1 sum digits out per frame, valid/ready on both sides.
module rrs_add
    import rrs_add_pkg::*;
#(
    parameter int  RADIX = 4,
    parameter int  WIDTH = 8,
    localparam int D     = digit_width(RADIX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] x_digit,
    input  logic [D-1:0] y_digit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_digit,
    output logic         out_last
);

    localparam int DELTA = online_delay(RADIX);
    localparam int STEPS = WIDTH + DELTA;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0] CNT_LAST    = CW'(STEPS - 1);
    localparam logic [CW-1:0] CNT_LAST_IN = CW'(WIDTH - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    sdig_t         w_q;
    sdig_t         z_q;
    logic          out_valid_q;
    logic [D-1:0]  out_digit_q;
    logic          out_last_q;

    logic          accept_s;
    logic          stall_free_s;
    logic          step_s;
    logic          emit_s;
    logic          first_s;
    logic          last_s;
    logic [D-1:0]  x_s;
    logic [D-1:0]  y_s;
    logic [D-1:0]  sum_s;
    sdig_t         w_d;
    sdig_t         z_d;

    // Step qualification; flush steps feed zero digit pairs and ignore in_valid.
    always_comb begin
        accept_s     = (state_q == ST_ACCEPT);
        stall_free_s = !out_valid_q || out_ready;
        first_s      = (cnt_q == {CW{1'b0}});
        last_s       = (cnt_q == CNT_LAST);
        emit_s       = (RADIX != 2) || !first_s;
        if (accept_s) begin
            step_s = in_valid && stall_free_s;
            x_s    = x_digit;
            y_s    = y_digit;
        end else begin
            step_s = stall_free_s;
            x_s    = {D{1'b0}};
            y_s    = {D{1'b0}};
        end
    end

    rrs_add_digit_sel #(
        .RADIX(RADIX),
        .D    (D)
    ) u_digit_sel (
        .first_i(first_s),
        .x_i    (x_s),
        .y_i    (y_s),
        .w_i    (w_q),
        .z_i    (z_q),
        .sum_o  (sum_s),
        .w_o    (w_d),
        .z_o    (z_d)
    );

    // Step sequencer, interim digit history and the registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCEPT;
            cnt_q       <= {CW{1'b0}};
            w_q         <= {SW{1'b0}};
            z_q         <= {SW{1'b0}};
            out_valid_q <= 1'b0;
            out_digit_q <= {D{1'b0}};
            out_last_q  <= 1'b0;
        end else if (step_s) begin
            out_valid_q <= emit_s;
            if (emit_s) begin
                out_digit_q <= sum_s;
                out_last_q  <= last_s;
            end else begin
                out_last_q  <= 1'b0;
            end
            if (last_s) begin
                state_q <= ST_ACCEPT;
                cnt_q   <= {CW{1'b0}};
                w_q     <= {SW{1'b0}};
                z_q     <= {SW{1'b0}};
            end else begin
                cnt_q <= cnt_q + CW'(1'b1);
                w_q   <= w_d;
                z_q   <= z_d;
                if (accept_s && (cnt_q == CNT_LAST_IN)) begin
                    state_q <= ST_FLUSH;
                end
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = accept_s && stall_free_s;
    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_rrs_add.sv
// Self-checking bench for rrs_add: directed vector table on radix 2/4/8, mid-frame reset,
// and throttled back-to-back random frames on radix 2, 4, 8 and 16 checked by value.
module tb_rrs_add;

    localparam int W  = 4;
    localparam int NI = 4;

    typedef logic signed [7:0] d8_t;
    typedef struct packed {
        int              k;
        d8_t [0:W-1]     x;
        d8_t [0:W-1]     y;
        d8_t [0:W]       o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_s  [NI];
    logic       in_ready_s  [NI];
    logic [4:0] x_s         [NI];
    logic [4:0] y_s         [NI];
    logic       out_valid_s [NI];
    logic       out_ready_s [NI];
    logic [4:0] out_s       [NI];
    logic       out_last_s  [NI];

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int RAD = 2 << gi;
        localparam int DW  = $clog2(RAD) + 1;
        logic [DW-1:0] od_s;
        rrs_add #(.RADIX(RAD), .WIDTH(W)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid_s[gi]),
            .in_ready (in_ready_s[gi]),
            .x_digit  (x_s[gi][DW-1:0]),
            .y_digit  (y_s[gi][DW-1:0]),
            .out_valid(out_valid_s[gi]),
            .out_ready(out_ready_s[gi]),
            .out_digit(od_s),
            .out_last (out_last_s[gi])
        );
        assign out_s[gi] = 5'($signed(od_s));
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sval(input logic [4:0] v);
        return int'($signed(v));
    endfunction

    // One frame at full throughput; checks digits, out_last, first-output latency, in_ready gap.
    task automatic run_vec(input int vi, input vec_t v);
        int k, xi, got, cyc, ir_low, first_acc;
        k = v.k; xi = 0; got = 0; cyc = 0; ir_low = 0; first_acc = -1;
        out_ready_s[k] = 1'b1;
        while (got < W + 1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid_s[k]) begin
                if (got == 0) first_acc = xi;
                check($sformatf("vec%0d_digit%0d", vi, got), sval(out_s[k]), int'($signed(v.o[got])));
                check($sformatf("vec%0d_last%0d", vi, got), int'(out_last_s[k]), (got == W) ? 1 : 0);
                got++;
            end
            if (xi < W) begin
                in_valid_s[k] = 1'b1;
                x_s[k] = v.x[xi][4:0];
                y_s[k] = v.y[xi][4:0];
            end else begin
                in_valid_s[k] = 1'b0;
                x_s[k] = 5'd0;
                y_s[k] = 5'd0;
            end
            #1;
            if (!in_ready_s[k]) ir_low++;
            if (in_valid_s[k] && in_ready_s[k]) xi++;
        end
        in_valid_s[k] = 1'b0;
        check($sformatf("vec%0d_count", vi), got, W + 1);
        check($sformatf("vec%0d_first_latency", vi), first_acc, (k == 0) ? 2 : 1);
        check($sformatf("vec%0d_inready_low", vi), ir_low, (k == 0) ? 2 : 1);
    endtask

    // Randomly throttled back-to-back frames; each frame's digits are summed and compared to x+y.
    task automatic run_random(input int k, input int nframes);
        int exp_q[$];
        int rad, amax, gen_idx, xval, yval, sent, done, got, acc, cyc, xd, yd, d, held;
        bit have_pair, stall_prev;
        rad = 2 << k; amax = rad - 1;
        gen_idx = 0; xval = 0; yval = 0; sent = 0; done = 0; got = 0; acc = 0; cyc = 0;
        xd = 0; yd = 0; held = 0; have_pair = 1'b0; stall_prev = 1'b0;
        while (done < nframes && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (stall_prev)
                check($sformatf("r%0d_stall_hold", rad), out_valid_s[k] ? sval(out_s[k]) : 99, held);
            out_ready_s[k] = ($urandom_range(0, 3) != 0);
            if (!have_pair && sent < nframes) begin
                xd = int'($urandom_range(0, 2 * amax)) - amax;
                yd = int'($urandom_range(0, 2 * amax)) - amax;
                xval = xval * rad + xd;
                yval = yval * rad + yd;
                gen_idx++;
                if (gen_idx == W) begin
                    exp_q.push_back(xval + yval);
                    xval = 0; yval = 0; gen_idx = 0; sent++;
                end
                have_pair = 1'b1;
            end
            in_valid_s[k] = have_pair && ($urandom_range(0, 3) != 0);
            x_s[k] = 5'(xd);
            y_s[k] = 5'(yd);
            #1;
            if (in_valid_s[k] && in_ready_s[k]) have_pair = 1'b0;
            if (out_valid_s[k] && out_ready_s[k]) begin
                d = sval(out_s[k]);
                check($sformatf("r%0d_digit_range", rad), int'(d >= -amax && d <= amax), 1);
                acc = acc * rad + d;
                got++;
                if (out_last_s[k]) begin
                    check($sformatf("r%0d_frame_len", rad), got, W + 1);
                    if (exp_q.size() == 0) check($sformatf("r%0d_extra_frame", rad), 1, 0);
                    else check($sformatf("r%0d_frame_value", rad), acc, exp_q.pop_front());
                    done++; got = 0; acc = 0;
                end else if (got > W) begin
                    check($sformatf("r%0d_missing_last", rad), got, W);
                    got = 0; acc = 0;
                end
            end
            stall_prev = out_valid_s[k] && !out_ready_s[k];
            held = sval(out_s[k]);
        end
        in_valid_s[k] = 1'b0;
        check($sformatf("r%0d_frames_done", rad), done, nframes);
    endtask

    initial begin
        vecs[0] = '{k: 1, x: {8'sd3, 8'sd3, 8'sd3, 8'sd3}, y: {8'sd1, 8'sd0, 8'sd0, 8'sd0},
                   o: {8'sd1, 8'sd1, 8'sd0, 8'sd0, -8'sd1}};
        vecs[1] = '{k: 1, x: {-8'sd3, -8'sd3, -8'sd3, -8'sd3}, y: {-8'sd3, -8'sd3, -8'sd3, -8'sd3},
                   o: {-8'sd1, -8'sd3, -8'sd3, -8'sd3, -8'sd2}};
        vecs[2] = '{k: 0, x: {8'sd1, 8'sd1, 8'sd1, 8'sd1}, y: {8'sd1, 8'sd0, 8'sd0, 8'sd0},
                   o: {8'sd1, 8'sd1, 8'sd0, -8'sd1, 8'sd1}};
        vecs[3] = '{k: 1, x: {8'sd0, 8'sd0, 8'sd0, 8'sd0}, y: {8'sd0, 8'sd0, 8'sd0, 8'sd0},
                   o: {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0}};
        vecs[4] = '{k: 0, x: {-8'sd1, -8'sd1, -8'sd1, -8'sd1}, y: {-8'sd1, -8'sd1, -8'sd1, -8'sd1},
                   o: {-8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd0}};
        vecs[5] = '{k: 1, x: {-8'sd3, 8'sd0, 8'sd2, -8'sd2}, y: {8'sd0, -8'sd3, 8'sd1, 8'sd0},
                   o: {-8'sd1, 8'sd0, 8'sd2, -8'sd1, -8'sd2}};
        vecs[6] = '{k: 2, x: {8'sd7, 8'sd0, 8'sd0, 8'sd0}, y: {8'sd1, 8'sd0, 8'sd0, 8'sd0},
                   o: {8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0}};
        vecs[7] = '{k: 0, x: {8'sd0, 8'sd0, 8'sd0, 8'sd0}, y: {8'sd0, 8'sd0, 8'sd0, 8'sd0},
                   o: {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0}};

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0; x_s[i] = 5'd0; y_s[i] = 5'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_out_valid%0d", i), int'(out_valid_s[i]), 0);
            check($sformatf("reset_out_digit%0d", i), sval(out_s[i]), 0);
            check($sformatf("reset_out_last%0d", i), int'(out_last_s[i]), 0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("reset_in_ready%0d", i), int'(in_ready_s[i]), 1);

        for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

        // Reset after digit 2 of a radix-4 frame, then a clean frame must follow.
        out_ready_s[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_s[1] = 1'b1;
            x_s[1] = vecs[0].x[i][4:0];
            y_s[1] = vecs[0].y[i][4:0];
        end
        @(negedge clk);
        in_valid_s[1] = 1'b0;
        check("midrst_pre_valid", int'(out_valid_s[1]), 1);
        check("midrst_pre_digit", sval(out_s[1]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid_s[1]), 0);
        check("midrst_out_digit", sval(out_s[1]), 0);
        check("midrst_out_last", int'(out_last_s[1]), 0);
        check("midrst_in_ready", int'(in_ready_s[1]), 1);
        run_vec(8, vecs[0]);

        fork
            run_random(0, 1000);
            run_random(1, 1000);
            run_random(2, 1000);
            run_random(3, 1000);
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
